dmem_arbiter: RTL and testbench

- Shares the single data-memory port (DMEM) between two requesters: M0 = miniRV core data port, M1 = debug/program loader.
- Sits between the bus block's memory side and DMEM.
- Round-robin arbitration, optional bursts via lock, read-return tagging across the DMEM read latency.
- One transaction is issued to DMEM per cycle at most.

---
 rtl/dmem_arbiter_if.sv | 67 ++++++
 rtl/dmem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports (M0 = miniRV core data port,
// M1 = debug/program loader) and the DMEM-side port of the data-memory arbiter.
//
// Signals per requester mX:
//   mX_req, mX_lock, mX_we, mX_addr, mX_wdata : requester -> arbiter
//   mX_gnt, mX_rvalid, mX_rdata               : arbiter -> requester
// DMEM side:
//   mem_addr, mem_we, mem_wdata : arbiter -> DMEM
//   mem_rdata                   : DMEM -> arbiter
// starve_o exists only when ARB_STARVE_GUARD_EN is defined.
//
// Modports: slave = arbiter view, master = requester/DMEM-environment view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_lock;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_lock;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

`ifdef ARB_STARVE_GUARD_EN
    logic          starve_o;
`endif

    modport slave (
`ifdef ARB_STARVE_GUARD_EN
        output starve_o,
`endif
        input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
`ifdef ARB_STARVE_GUARD_EN
        input  starve_o,
`endif
        output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single DMEM port between M0 (core data port) and
// M1 (debug/program loader). Round-robin arbitration, lock-based bursts capped
// at MAX_BURST grants, and read-return tagging across the RD_LAT-cycle DMEM
// read latency. At most one transaction is issued to DMEM per cycle.
//
// Ports:
//   clk_i : system clock
//   rst_i : asynchronous reset, active-high
//   bus   : dmem_arbiter_if.slave (both requester ports plus DMEM side)
//
// Optional feature macro: ARB_STARVE_GUARD_EN. When defined, per-master 8-bit
// wait counters force a grant to a master that has waited MAX_WAIT cycles,
// breaking any lock, and bus.starve_o pulses for that cycle.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8,
    parameter int MAX_WAIT  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_arbiter_if.slave   bus
);

    // Reject out-of-range configurations at elaboration time.
    generate
        if (RD_LAT < 1 || RD_LAT > 4 || MAX_BURST < 2 || MAX_BURST > 255 ||
            MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_params
            $error("dmem_arbiter: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    state_t        state, state_nxt;
    logic          rr_last, rr_last_nxt;
    logic [7:0]    burst_cnt, burst_cnt_nxt;
    logic [7:0]    burst_inc;
    logic          lock_hold;
    logic          owner;
    logic          win;
    logic          gnt0, gnt1;
    logic          any_gnt;
    logic          sel_we;
    logic          rd_push;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_id;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0_q, rdata1_q;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
    logic [7:0] wait0, wait1;
    logic       starve0, starve1;
    logic       starve_fire;

    // A master only counts as starving while it is still requesting, so a
    // stale counter never produces a grant to an idle master.
    assign starve0 = bus.m0_req && (wait0 >= WAIT_LIMIT);
    assign starve1 = bus.m1_req && (wait1 >= WAIT_LIMIT);
    assign bus.starve_o = starve_fire;
`endif

    // State register plus round-robin history and burst length.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ARB;
            rr_last   <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_last   <= rr_last_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Grant decision. A locked owner that still requests keeps the port;
    // otherwise the cycle is arbitrated normally, so dropping the request
    // while locked costs no idle bubble. A burst ending on the cap leaves
    // rr_last pointing at the owner, which hands the next tie to the other
    // master.
    always_comb begin
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        state_nxt     = state;
        rr_last_nxt   = rr_last;
        burst_cnt_nxt = burst_cnt;
        burst_inc     = burst_cnt + 8'd1;
        owner         = 1'b0;
        win           = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        starve_fire   = 1'b0;
`endif
        lock_hold = ((state == LOCK0) && bus.m0_req) ||
                    ((state == LOCK1) && bus.m1_req);

        if (lock_hold) begin
            owner         = (state == LOCK1);
            gnt0          = !owner;
            gnt1          = owner;
            burst_cnt_nxt = burst_inc;
            if (!(owner ? bus.m1_lock : bus.m0_lock) || (burst_inc >= BURST_LIMIT)) begin
                state_nxt     = ARB;
                burst_cnt_nxt = '0;
            end
        end else begin
            state_nxt     = ARB;
            burst_cnt_nxt = '0;
            if (bus.m0_req || bus.m1_req) begin
                win         = (bus.m0_req && bus.m1_req) ? !rr_last : bus.m1_req;
                gnt0        = !win;
                gnt1        = win;
                rr_last_nxt = win;
                if (win ? bus.m1_lock : bus.m0_lock) begin
                    state_nxt     = win ? LOCK1 : LOCK0;
                    burst_cnt_nxt = 8'd1;
                end
            end
        end

`ifdef ARB_STARVE_GUARD_EN
        if (starve0 || starve1) begin
            win           = (starve0 && starve1) ? !rr_last : starve1;
            gnt0          = !win;
            gnt1          = win;
            rr_last_nxt   = win;
            state_nxt     = ARB;
            burst_cnt_nxt = '0;
            starve_fire   = 1'b1;
        end
`endif

        if (rst_i) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            starve_fire = 1'b0;
`endif
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign sel_we  = gnt1 ? bus.m1_we : bus.m0_we;
    assign rd_push = any_gnt & !sel_we;

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.mem_we    = any_gnt & sel_we;
    assign bus.mem_addr  = !any_gnt ? addr_q  : (gnt1 ? bus.m1_addr  : bus.m0_addr);
    assign bus.mem_wdata = !any_gnt ? wdata_q : (gnt1 ? bus.m1_wdata : bus.m0_wdata);

    // Remember the last issued address/data so the DMEM bus stays quiet
    // between transactions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (any_gnt) begin
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
        end
    end

    // Read tag pipe: one entry per cycle, tail lines up with mem_rdata.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            pipe_v[0]  <= rd_push;
            pipe_id[0] <= gnt1;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    assign rvalid0 = pipe_v[RD_LAT-1] & !pipe_id[RD_LAT-1];
    assign rvalid1 = pipe_v[RD_LAT-1] &  pipe_id[RD_LAT-1];

    // Each requester's rdata follows mem_rdata on its own return cycle and
    // otherwise keeps the last word it was handed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0) rdata0_q <= bus.mem_rdata;
            if (rvalid1) rdata1_q <= bus.mem_rdata;
        end
    end

    assign bus.m0_rvalid = rvalid0;
    assign bus.m1_rvalid = rvalid1;
    assign bus.m0_rdata  = rvalid0 ? bus.mem_rdata : rdata0_q;
    assign bus.m1_rdata  = rvalid1 ? bus.mem_rdata : rdata1_q;

`ifdef ARB_STARVE_GUARD_EN
    // Wait counters: count ungranted request cycles, saturating at 255.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait0 <= '0;
            wait1 <= '0;
        end else begin
            wait0 <= (bus.m0_req && !gnt0) ? ((wait0 == 8'hFF) ? wait0 : wait0 + 8'd1) : 8'd0;
            wait1 <= (bus.m1_req && !gnt1) ? ((wait1 == 8'hFF) ? wait1 : wait1 + 8'd1) : 8'd0;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a small DMEM model
// (RD_LAT-cycle read latency) and a scoreboard of expected read returns.
// Builds with or without ARB_STARVE_GUARD_EN.
module tb_dmem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;
`ifdef ARB_STARVE_GUARD_EN
    localparam int MAX_BURST = 255;
    localparam int MAX_WAIT  = 4;
`else
    localparam int MAX_BURST = 8;
    localparam int MAX_WAIT  = 16;
`endif

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int errors = 0;
    int checks = 0;

    rd_exp_t     sb[$];
    logic [31:0] exp_mem[64];
    logic [31:0] hold0, hold1;
    logic [31:0] last_addr;
`ifdef ARB_STARVE_GUARD_EN
    logic        exp_starve = 1'b0;
`endif

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    dmem_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memInit(int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // DMEM model: writes on the issue edge, reads return RD_LAT cycles later.
    logic [31:0] dmem[64];
    logic [31:0] rd_pipe[RD_LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) dmem[i] <= memInit(i);
        end else if (bus.mem_we) begin
            dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
        rd_pipe[0] <= dmem[bus.mem_addr[7:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Compare read-return outputs against the scoreboard front.
    task automatic checkReturns();
        logic    ev0, ev1;
        rd_exp_t e;
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.id) ev1 = 1'b1;
            else      ev0 = 1'b1;
            if (ev0) hold0 = e.data;
            if (ev1) hold1 = e.data;
        end
        checkOutput("rvalid0", 32'(bus.m0_rvalid), 32'(ev0));
        checkOutput("rvalid1", 32'(bus.m1_rvalid), 32'(ev1));
        checkOutput("rdata0", bus.m0_rdata, hold0);
        checkOutput("rdata1", bus.m1_rdata, hold1);
    endtask

    // Drive one cycle of requests; exp_win = 0/1 for the expected winner, -1 for none.
    task automatic applyStimulus(
        input logic r0, input logic l0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic l1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input int exp_win, input string tag);
        logic [31:0] ea, ed;
        logic        ew;
        rd_exp_t     e;
        bus.m0_req = r0; bus.m0_lock = l0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_lock = l1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
        @(negedge clk);
        checkReturns();
        checkOutput({tag, "_gnt0"}, 32'(bus.m0_gnt), 32'(exp_win == 0));
        checkOutput({tag, "_gnt1"}, 32'(bus.m1_gnt), 32'(exp_win == 1));
`ifdef ARB_STARVE_GUARD_EN
        checkOutput({tag, "_starve"}, 32'(bus.starve_o), 32'(exp_starve));
`endif
        if (exp_win >= 0) begin
            ea = (exp_win == 1) ? a1 : a0;
            ed = (exp_win == 1) ? d1 : d0;
            ew = (exp_win == 1) ? w1 : w0;
            checkOutput({tag, "_addr"}, bus.mem_addr, ea);
            checkOutput({tag, "_we"}, 32'(bus.mem_we), 32'(ew));
            last_addr = ea;
            if (ew) begin
                checkOutput({tag, "_wdata"}, bus.mem_wdata, ed);
                exp_mem[ea[7:2]] = ed;
            end else begin
                e.id   = (exp_win == 1);
                e.data = exp_mem[ea[7:2]];
                e.due  = cyc + RD_LAT;
                sb.push_back(e);
            end
        end else begin
            checkOutput({tag, "_we"}, 32'(bus.mem_we), 32'd0);
            checkOutput({tag, "_addr_hold"}, bus.mem_addr, last_addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, -1, "idle");
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb.size() > 0; k++) idleCycle();
        checkOutput("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Assert reset (with M0 requesting) and check every output is quiet.
    task automatic resetDut();
        rst = 1'b1;
        bus.m0_req = 1'b1; bus.m0_lock = 1'b0; bus.m0_we = 1'b0;
        bus.m0_addr = 32'h10; bus.m0_wdata = 32'h0;
        bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m1_we = 1'b0;
        bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0;
        sb.delete();
        hold0 = '0;
        hold1 = '0;
        last_addr = '0;
        for (int i = 0; i < 64; i++) exp_mem[i] = memInit(i);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_gnt0", 32'(bus.m0_gnt), 32'd0);
            checkOutput("rst_gnt1", 32'(bus.m1_gnt), 32'd0);
            checkOutput("rst_rvalid0", 32'(bus.m0_rvalid), 32'd0);
            checkOutput("rst_rvalid1", 32'(bus.m1_rvalid), 32'd0);
            checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
            checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
            checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
            checkOutput("rst_rdata0", bus.m0_rdata, 32'd0);
            checkOutput("rst_rdata1", bus.m1_rdata, 32'd0);
        end
        bus.m0_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int ew;
        resetDut();

        $display("[TB] single M0 read, RD_LAT latency");
        applyStimulus(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, "rd10");
        drain();

        $display("[TB] round-robin alternation");
        resetDut();
        for (int i = 0; i < 6; i++)
            applyStimulus(1, 0, 0, 32'h20, 32'h0, 1, 0, 0, 32'h40, 32'h0, i % 2,
                          $sformatf("alt%0d", i));
        drain();

        resetDut();
`ifdef ARB_STARVE_GUARD_EN
        $display("[TB] M1 locked, starvation guard rescues M0");
        for (int i = 0; i < 20; i++) begin
            ew = (i % 5 == 0) ? 0 : 1;
            exp_starve = (i % 5 == 0) && (i > 0);
            applyStimulus(1, 0, 0, 32'h80, 32'h0, 1, 1, 0, 32'h84, 32'h0, ew,
                          $sformatf("starve%0d", i));
        end
        exp_starve = 1'b0;
`else
        $display("[TB] M1 locked burst capped at MAX_BURST");
        for (int i = 0; i < 20; i++) begin
            ew = (i == 0 || i == 9 || i == 18) ? 0 : 1;
            applyStimulus(1, 0, 0, 32'h80, 32'h0, 1, 1, 0, 32'h84, 32'h0, ew,
                          $sformatf("burst%0d", i));
        end
`endif
        drain();

        $display("[TB] interleaved reads and a write");
        applyStimulus(1, 0, 0, 32'h04, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, "ilv_rd04");
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h08, 32'h0, 1, "ilv_rd08");
        applyStimulus(1, 0, 1, 32'h0C, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0, 0, "ilv_wr0c");
        idleCycle();
        applyStimulus(1, 0, 0, 32'h0C, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, "ilv_rd0c");
        drain();

        $display("[TB] reset with a read in flight");
        applyStimulus(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, "flush_rd");
        resetDut();
        repeat (4) idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
